// File: rtl/rc_vc_unit_pkg.sv
// NoC parameter set shared by the route computation unit: mesh geometry,
// address widths and the flit/port/mode encodings.
package rc_vc_unit_pkg;

  localparam int MESH_SIZE_X      = 5;
  localparam int MESH_SIZE_Y      = 5;
  localparam int DEST_ADDR_SIZE_X = 3;
  localparam int DEST_ADDR_SIZE_Y = 3;
  localparam int VC_NUM           = 4;

  typedef enum logic {
    XY = 1'b0,
    YX = 1'b1
  } routing_mode_t;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    EAST  = 3'd4
  } port_t;

  typedef enum logic {
    VC_IDLE   = 1'b0,
    VC_ROUTED = 1'b1
  } vc_state_e;

  function automatic logic is_head(input flit_label_t label);
    return (label == HEAD) || (label == HEADTAIL);
  endfunction

endpackage

// File: rtl/rc_vc_unit_compute.sv
// Combinational output-port selection (XY or YX order) and mesh range check
// for the single flit presented this cycle.
module rc_compute
  import rc_vc_unit_pkg::*;
#(
  parameter int X_CURRENT        = MESH_SIZE_X / 2,
  parameter int Y_CURRENT        = MESH_SIZE_Y / 2,
  parameter int MESH_X           = MESH_SIZE_X,
  parameter int MESH_Y           = MESH_SIZE_Y,
  parameter int DEST_ADDR_SIZE_X = rc_vc_unit_pkg::DEST_ADDR_SIZE_X,
  parameter int DEST_ADDR_SIZE_Y = rc_vc_unit_pkg::DEST_ADDR_SIZE_Y
) (
  input  routing_mode_t               mode_i,
  input  logic [DEST_ADDR_SIZE_X-1:0] x_dest_i,
  input  logic [DEST_ADDR_SIZE_Y-1:0] y_dest_i,
  output port_t                       port_o,
  output logic                        in_mesh_o
);

  logic x_lt, x_gt, y_lt, y_gt;

  // Zero-extended to int so the mesh bound is never truncated to the port width.
  always_comb begin
    x_lt      = int'(x_dest_i) < X_CURRENT;
    x_gt      = int'(x_dest_i) > X_CURRENT;
    y_lt      = int'(y_dest_i) < Y_CURRENT;
    y_gt      = int'(y_dest_i) > Y_CURRENT;
    in_mesh_o = (int'(x_dest_i) < MESH_X) && (int'(y_dest_i) < MESH_Y);
  end

  always_comb begin
    port_o = LOCAL;
    if (mode_i == XY) begin
      if (x_lt)      port_o = WEST;
      else if (x_gt) port_o = EAST;
      else if (y_lt) port_o = NORTH;
      else if (y_gt) port_o = SOUTH;
    end else begin
      if (y_lt)      port_o = NORTH;
      else if (y_gt) port_o = SOUTH;
      else if (x_lt) port_o = WEST;
      else if (x_gt) port_o = EAST;
    end
  end

endmodule

// File: rtl/rc_vc_unit.sv
// Per-VC registered route table: a head flit resolves its output port once and
// the route is held for that VC until its release pulse.
module rc_vc_unit
  import rc_vc_unit_pkg::*;
#(
  parameter int X_CURRENT        = MESH_SIZE_X / 2,
  parameter int Y_CURRENT        = MESH_SIZE_Y / 2,
  parameter int VC_NUM           = rc_vc_unit_pkg::VC_NUM,
  parameter int DEST_ADDR_SIZE_X = rc_vc_unit_pkg::DEST_ADDR_SIZE_X,
  parameter int DEST_ADDR_SIZE_Y = rc_vc_unit_pkg::DEST_ADDR_SIZE_Y,
  localparam int VC_W            = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flit_valid_i,
  input  logic [VC_W-1:0]             vc_id_i,
  input  flit_label_t                 flit_label_i,
  input  logic [DEST_ADDR_SIZE_X-1:0] x_dest_i,
  input  logic [DEST_ADDR_SIZE_Y-1:0] y_dest_i,
  input  routing_mode_t               mode_i,
  input  logic [VC_NUM-1:0]           release_i,
  output logic [VC_NUM-1:0]           route_valid_o,
  output port_t [VC_NUM-1:0]          out_port_o,
  output logic                        dest_error_o,
  output logic                        proto_error_o
);

  port_t             comp_port;
  logic              in_mesh;
  logic              head_in;
  logic [VC_NUM-1:0] proto_hit;
  logic              dest_err_d, dest_err_q;
  logic              proto_err_d, proto_err_q;

  rc_compute #(
    .X_CURRENT        (X_CURRENT),
    .Y_CURRENT        (Y_CURRENT),
    .MESH_X           (MESH_SIZE_X),
    .MESH_Y           (MESH_SIZE_Y),
    .DEST_ADDR_SIZE_X (DEST_ADDR_SIZE_X),
    .DEST_ADDR_SIZE_Y (DEST_ADDR_SIZE_Y)
  ) u_compute (
    .mode_i    (mode_i),
    .x_dest_i  (x_dest_i),
    .y_dest_i  (y_dest_i),
    .port_o    (comp_port),
    .in_mesh_o (in_mesh)
  );

  assign head_in = flit_valid_i && is_head(flit_label_i);

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    vc_state_e state_q, state_d;
    port_t     port_q, port_d;
    logic      head_hit;

    assign head_hit = head_in && (vc_id_i == VC_W'(v));

    // A release in the same cycle frees the VC first, so a new head is accepted.
    always_comb begin
      state_d = state_q;
      port_d  = port_q;
      unique case (state_q)
        VC_IDLE: begin
          if (head_hit && in_mesh) begin
            state_d = VC_ROUTED;
            port_d  = comp_port;
          end
        end
        VC_ROUTED: begin
          if (release_i[v]) begin
            state_d = VC_IDLE;
            if (head_hit && in_mesh) begin
              state_d = VC_ROUTED;
              port_d  = comp_port;
            end
          end
        end
        default: state_d = VC_IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= VC_IDLE;
        port_q  <= LOCAL;
      end else begin
        state_q <= state_d;
        port_q  <= port_d;
      end
    end

    assign proto_hit[v]     = head_hit && in_mesh && (state_q == VC_ROUTED) && !release_i[v];
    assign route_valid_o[v] = (state_q == VC_ROUTED);
    assign out_port_o[v]    = port_q;
  end

  // An out-of-mesh head reports only the destination error, keeping the pulses exclusive.
  always_comb begin
    dest_err_d  = head_in && !in_mesh;
    proto_err_d = |proto_hit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dest_err_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      dest_err_q  <= dest_err_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign dest_error_o  = dest_err_q;
  assign proto_error_o = proto_err_q;

endmodule

// File: tb/tb_rc_vc_unit.sv
// Directed bench for rc_vc_unit on a 5x5 mesh at router (2,2) with 4 VCs.
module tb_rc_vc_unit;
  import rc_vc_unit_pkg::*;

  logic                  clk;
  logic                  rst;
  logic                  flit_valid;
  logic [1:0]            vc_id;
  flit_label_t           flit_label;
  logic [2:0]            x_dest;
  logic [2:0]            y_dest;
  routing_mode_t         mode;
  logic [3:0]            rel;
  logic [3:0]            route_valid;
  port_t [3:0]           out_port;
  logic                  dest_error;
  logic                  proto_error;

  int n_checks = 0;
  int n_fail   = 0;

  rc_vc_unit #(
    .X_CURRENT        (2),
    .Y_CURRENT        (2),
    .VC_NUM           (4),
    .DEST_ADDR_SIZE_X (3),
    .DEST_ADDR_SIZE_Y (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flit_valid_i  (flit_valid),
    .vc_id_i       (vc_id),
    .flit_label_i  (flit_label),
    .x_dest_i      (x_dest),
    .y_dest_i      (y_dest),
    .mode_i        (mode),
    .release_i     (rel),
    .route_valid_o (route_valid),
    .out_port_o    (out_port),
    .dest_error_o  (dest_error),
    .proto_error_o (proto_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic port_t exp_port(input routing_mode_t md, input int x, input int y);
    if (md == XY) begin
      if (x < 2) return WEST;
      if (x > 2) return EAST;
      if (y < 2) return NORTH;
      if (y > 2) return SOUTH;
    end else begin
      if (y < 2) return NORTH;
      if (y > 2) return SOUTH;
      if (x < 2) return WEST;
      if (x > 2) return EAST;
    end
    return LOCAL;
  endfunction

  // Drive one cycle of stimulus, step past the edge, return inputs to idle.
  task automatic send(input logic valid, input int vc, input flit_label_t lbl,
                      input int x, input int y, input routing_mode_t md,
                      input logic [3:0] r);
    logic [31:0] vv, xv, yv;
    vv = vc; xv = x; yv = y;
    flit_valid = valid;
    vc_id      = vv[1:0];
    flit_label = lbl;
    x_dest     = xv[2:0];
    y_dest     = yv[2:0];
    mode       = md;
    rel        = r;
    @(posedge clk);
    #1;
    flit_valid = 1'b0;
    flit_label = BODY;
    rel        = '0;
  endtask

  initial begin
    rst = 1'b0; flit_valid = 1'b0; vc_id = '0; flit_label = BODY;
    x_dest = '0; y_dest = '0; mode = XY; rel = '0;
    #3;
    check_eq("reset_valid", 32'(route_valid), 32'h0);
    check_eq("reset_port",  32'(out_port),    32'h0);
    check_eq("reset_derr",  32'(dest_error),  32'h0);
    check_eq("reset_perr",  32'(proto_error), 32'h0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    send(1'b1, 0, HEAD, 0, 3, XY, 4'b0000);
    check_eq("xy_valid", 32'(route_valid), 32'h1);
    check_eq("xy_port",  32'(out_port[0]), 32'(WEST));
    send(1'b1, 0, TAIL, 0, 0, XY, 4'b0001);
    check_eq("xy_release_valid", 32'(route_valid), 32'h0);
    check_eq("xy_release_port",  32'(out_port[0]), 32'(WEST));

    send(1'b1, 1, HEAD, 0, 3, YX, 4'b0000);
    check_eq("yx_port", 32'(out_port[1]), 32'(SOUTH));
    send(1'b1, 2, HEADTAIL, 2, 2, XY, 4'b0000);
    check_eq("local_port",  32'(out_port[2]), 32'(LOCAL));
    check_eq("b2b_valid",   32'(route_valid), 32'h6);

    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 5; x++) begin
        for (int y = 0; y < 5; y++) begin
          send(1'b1, 3, HEAD, x, y, routing_mode_t'(m), 4'b0000);
          check_eq($sformatf("sweep_port_m%0d_x%0d_y%0d", m, x, y),
                   32'(out_port[3]), 32'(exp_port(routing_mode_t'(m), x, y)));
          check_eq("sweep_valid", 32'(route_valid[3]), 32'h1);
          send(1'b0, 3, BODY, 0, 0, XY, 4'b1000);
          check_eq("sweep_release", 32'(route_valid[3]), 32'h0);
        end
      end
    end

    send(1'b1, 0, HEAD, 7, 1, XY, 4'b0000);
    check_eq("oom_derr",  32'(dest_error),     32'h1);
    check_eq("oom_perr",  32'(proto_error),    32'h0);
    check_eq("oom_valid", 32'(route_valid[0]), 32'h0);
    send(1'b0, 0, BODY, 0, 0, XY, 4'b0000);
    check_eq("oom_pulse_end", 32'(dest_error), 32'h0);
    send(1'b1, 0, HEADTAIL, 1, 5, YX, 4'b0000);
    check_eq("oom_y_derr",  32'(dest_error),     32'h1);
    check_eq("oom_y_valid", 32'(route_valid[0]), 32'h0);

    send(1'b1, 0, BODY, 4, 4, XY, 4'b0001);
    check_eq("idle_body_valid", 32'(route_valid[0]), 32'h0);
    check_eq("idle_body_derr",  32'(dest_error),     32'h0);
    check_eq("idle_body_perr",  32'(proto_error),    32'h0);

    send(1'b1, 1, HEAD, 4, 2, XY, 4'b0000);
    check_eq("proto_perr",  32'(proto_error),    32'h1);
    check_eq("proto_derr",  32'(dest_error),     32'h0);
    check_eq("proto_port",  32'(out_port[1]),    32'(SOUTH));
    check_eq("proto_valid", 32'(route_valid[1]), 32'h1);
    send(1'b1, 1, TAIL, 0, 0, XY, 4'b0000);
    check_eq("proto_pulse_end", 32'(proto_error), 32'h0);
    check_eq("tail_no_change",  32'(out_port[1]), 32'(SOUTH));

    send(1'b1, 1, HEAD, 4, 2, XY, 4'b0010);
    check_eq("relhead_port",  32'(out_port[1]),    32'(EAST));
    check_eq("relhead_valid", 32'(route_valid[1]), 32'h1);
    check_eq("relhead_perr",  32'(proto_error),    32'h0);

    send(1'b1, 0, HEAD, 4, 4, XY, 4'b0000);
    send(1'b1, 3, HEAD, 0, 0, YX, 4'b0000);
    check_eq("pre_reset_valid", 32'(route_valid), 32'hF);
    check_eq("pre_reset_port3", 32'(out_port[3]), 32'(NORTH));
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_reset_valid", 32'(route_valid), 32'h0);
    check_eq("async_reset_port",  32'(out_port),    32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
